// File: rtl/pattern_detector_param.sv
// Programmable serial pattern detector with Mealy/Moore match outputs and a
// saturating match counter. Bits are consumed only on enable strobes.
module pattern_detector_param #(
  parameter int               WIDTH         = 4,
  parameter int               COUNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = 4'b1101,
  localparam int              FW            = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   a,
  input  logic                   overlap,
  input  logic                   pattern_load,
  input  logic [WIDTH-1:0]       pattern_data,
  output logic                   match_mealy,
  output logic                   match_moore,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [WIDTH-1:0]       history,
  output logic [FW-1:0]          dbg_fill
);

  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH - 1);

  logic [WIDTH-1:0]       r_pattern;
  logic [WIDTH-1:0]       r_history;
  logic [FW-1:0]          r_fill;
  logic                   r_moore;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [WIDTH-1:0]       w_next_hist;
  logic                   w_accept;
  logic                   w_hit;
  logic [FW-1:0]          w_fill_nxt;
  logic [COUNT_WIDTH-1:0] w_count_nxt;

  // A bit is accepted only on a strobe that is not a load; load wins.
  assign w_accept    = enable & ~pattern_load & ~reset;
  assign w_next_hist = {r_history[WIDTH-2:0], a};
  // Requiring a full fill stops matches against the zero-filled history.
  assign w_hit       = w_accept & (r_fill == FILL_MAX) & (w_next_hist == r_pattern);

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_hit && !overlap) begin
      w_fill_nxt = '0;
    end else if (r_fill != FILL_MAX) begin
      w_fill_nxt = r_fill + FW'(1);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_hit && (r_count != {COUNT_WIDTH{1'b1}})) begin
      w_count_nxt = r_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pattern <= RESET_PATTERN;
      r_history <= '0;
      r_fill    <= '0;
      r_moore   <= 1'b0;
      r_count   <= '0;
    end else if (pattern_load) begin
      r_pattern <= pattern_data;
      r_fill    <= '0;
      r_moore   <= 1'b0;
    end else if (enable) begin
      r_history <= w_next_hist;
      r_fill    <= w_fill_nxt;
      r_moore   <= w_hit;
      r_count   <= w_count_nxt;
    end
  end

  assign match_mealy = w_hit;
  assign match_moore = r_moore;
  assign match_count = r_count;
  assign history     = r_history;
  assign dbg_fill    = r_fill;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: directed scenarios plus random traffic,
// both checked against a bit-list reference model of the detector.
module tb_pattern_detector_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       a = 1'b0;
  logic       overlap = 1'b1;
  logic       pattern_load = 1'b0;
  logic [3:0] pattern_data = 4'b0000;

  logic       mealy_a, moore_a, mealy_b, moore_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [3:0] hist_a, hist_b;
  logic [1:0] fill_a, fill_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pattern_detector_param #(.WIDTH(4), .COUNT_WIDTH(8), .RESET_PATTERN(4'b1101)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .a(a), .overlap(overlap),
    .pattern_load(pattern_load), .pattern_data(pattern_data),
    .match_mealy(mealy_a), .match_moore(moore_a), .match_count(count_a),
    .history(hist_a), .dbg_fill(fill_a));

  pattern_detector_param #(.WIDTH(4), .COUNT_WIDTH(2), .RESET_PATTERN(4'b1101)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .a(a), .overlap(overlap),
    .pattern_load(pattern_load), .pattern_data(pattern_data),
    .match_mealy(mealy_b), .match_moore(moore_b), .match_count(count_b),
    .history(hist_b), .dbg_fill(fill_b));

  // Reference model: the list of accepted bits, bits since the last restart,
  // and an unbounded hit total clipped to each counter's range on compare.
  logic [3:0] m_pattern = 4'b1101;
  bit         m_bits[$];
  int         m_since = 0;
  int         m_hits = 0;
  logic       m_moore = 1'b0;

  function automatic logic [3:0] m_window(input bit with_new, input logic nb);
    logic [3:0] w;
    int n;
    w = 4'b0000;
    n = m_bits.size();
    for (int i = 0; i < 4; i++) begin
      int idx;
      if (with_new && i == 0) begin
        w[0] = nb;
      end else begin
        idx = with_new ? n - i : n - 1 - i;
        w[i] = (idx >= 0) ? m_bits[idx] : 1'b0;
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("moore_a", 32'(moore_a), 32'(m_moore));
    chk("moore_b", 32'(moore_b), 32'(m_moore));
    chk("count_a", 32'(count_a), (m_hits > 255) ? 32'd255 : 32'(m_hits));
    chk("count_b", 32'(count_b), (m_hits > 3) ? 32'd3 : 32'(m_hits));
    chk("hist_a", 32'(hist_a), 32'(m_window(1'b0, 1'b0)));
    chk("hist_b", 32'(hist_b), 32'(m_window(1'b0, 1'b0)));
    chk("fill_a", 32'(fill_a), (m_since > 3) ? 32'd3 : 32'(m_since));
  endtask

  // One clock cycle: drive, check the combinational match, clock, check state.
  task automatic step(input logic rst, input logic en, input logic ain,
                      input logic ld, input logic [3:0] pd, input logic ovl);
    bit acc, hit;
    @(negedge clock);
    reset = rst; enable = en; a = ain; pattern_load = ld; pattern_data = pd; overlap = ovl;
    #1;
    acc = !rst && en && !ld;
    hit = acc && (m_since + 1 >= 4) && (m_window(1'b1, ain) == m_pattern);
    chk("mealy_a", 32'(mealy_a), 32'(hit));
    chk("mealy_b", 32'(mealy_b), 32'(hit));
    @(posedge clock);
    if (rst) begin
      m_pattern = 4'b1101; m_bits.delete(); m_since = 0; m_hits = 0; m_moore = 1'b0;
    end else if (ld) begin
      m_pattern = pd; m_since = 0; m_moore = 1'b0;
    end else if (en) begin
      m_bits.push_back(ain);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      m_moore = hit;
      if (hit) m_hits++;
      m_since = (hit && !ovl) ? 0 : m_since + 1;
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic accept(input logic ain, input logic ovl);
    step(1'b0, 1'b1, ain, 1'b0, 4'b0000, ovl);
  endtask

  task automatic idle(input logic ain, input logic ovl);
    step(1'b0, 1'b0, ain, 1'b0, 4'b0000, ovl);
  endtask

  logic [6:0] stream = 7'b1101101;

  initial begin
    // Overlapping default-pattern stream.
    do_reset();
    for (int i = 6; i >= 0; i--) accept(stream[i], 1'b1);
    chk("s1_count", 32'(count_a), 32'd2);
    chk("s1_hist", 32'(hist_a), 32'h0000000d);

    // Same stream, non-overlapping.
    do_reset();
    for (int i = 6; i >= 0; i--) accept(stream[i], 1'b0);
    chk("s2_count", 32'(count_a), 32'd1);

    // Idle strobes in the middle of a match.
    do_reset();
    accept(1'b1, 1'b1); accept(1'b1, 1'b1); accept(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b1);
    accept(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
    chk("s3_moore_hold", 32'(moore_a), 32'd1);

    // Load all-zero pattern with a concurrent strobe, then four zeros.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1);
    chk("s4_hist_after_load", 32'(hist_a), 32'h0000000d);
    for (int i = 0; i < 4; i++) accept(1'b0, 1'b1);
    chk("s4_hit_moore", 32'(moore_a), 32'd1);

    // Saturation of the narrow counter.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) accept(1'b1, 1'b1);
    chk("s5_count_b", 32'(count_b), 32'd3);
    chk("s5_count_a", 32'(count_a), 32'd5);

    // Reset in the middle of a pattern.
    do_reset();
    accept(1'b1, 1'b1); accept(1'b1, 1'b1); accept(1'b0, 1'b1);
    do_reset();
    chk("s6_count", 32'(count_a), 32'd0);
    chk("s6_hist", 32'(hist_a), 32'd0);
    accept(1'b1, 1'b1);

    // Random traffic with occasional loads, overlap changes and resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] pd;
      r  = $urandom_range(0, 99);
      pd = 4'($urandom_range(0, 15));
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, pd, 1'b1);
      else if (r < 6)  step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                            ($urandom_range(0, 1) == 1) ? pd : 4'b0101, 1'($urandom_range(0, 1)));
      else             step(1'b0, 1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)), 1'b0,
                            pd, 1'($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
